pixel_scheduler: RTL and testbench
==================================

// Module: pixel_scheduler
// PURPOSE
// - Frame-level sequencer for the pixel engines: generates raster-order (x,y) coordinates and hands them
//   round-robin to NUM_ENGINES engines, skipping any engine that is busy or whose result queue is full.
// - On the collect side, watches every engine-queue head, pops the head matching the next expected raster
//   coordinate, and emits one in-order pixel stream (with colour) to the frame writer.
// PARAMETERS
// - NUM_ENGINES  4    number of engine/queue pairs served
// - DATA_WIDTH   32   coordinate width (matches engine and queue ports)
// - RBG_SIZE     24   colour width
// - X_RES        640  pixels per line
// - Y_RES        480  lines per frame
// PORTS
// - clk          in   1                      clock
// - reset        in   1                      synchronous, active-high
// - start        in   1                      1-cycle pulse: begin a frame (honoured only in IDLE)
// - eng_ready    in   NUM_ENGINES            engine i can accept a coordinate
// - queue_full   in   NUM_ENGINES            full_queue flag from engine i's result queue
// - eng_valid    out  NUM_ENGINES            one-hot issue strobe; transfer when eng_valid[i]&&eng_ready[i]
// - eng_x/eng_y  out  DATA_WIDTH each        issued coordinate, broadcast to all engines
// - head_valid   in   NUM_ENGINES            queue i head holds a valid entry
// - head_x/y     in   NUM_ENGINES*DATA_WIDTH queue head coordinates, engine i at [i*DATA_WIDTH +: DATA_WIDTH]
// - head_colour  in   NUM_ENGINES*RBG_SIZE   queue head colours, same packing
// - pop          out  NUM_ENGINES            one-hot, 1 cycle: dequeue head of queue i
// - out_valid    out  1                      output pixel valid
// - out_ready    in   1                      downstream accepts; transfer when out_valid&&out_ready
// - out_x/out_y  out  DATA_WIDTH each        output coordinate
// - out_colour   out  RBG_SIZE               output colour
// - out_sof/eol  out  1 each                 out pixel is (0,0) / has x==X_RES-1
// - busy, done   out  1 each                 frame in progress / 1-cycle pulse on final output transfer
// - err_multi    out  1                      sticky: >1 queue head matched expected coordinate
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0, issue/expect coords=(0,0); all outputs 0 incl. err_multi. Reset mid-frame
//   aborts immediately; no pop or eng_valid is asserted in the reset cycle.
// - FSM: IDLE -start-> RUN; RUN -last coord (X_RES-1,Y_RES-1) issued-> DRAIN; DRAIN -last pixel transferred
//   out-> DONE; DONE -> IDLE next cycle (done pulses on the final transfer cycle). busy=1 in RUN and DRAIN.
// - Issue (RUN only): eligible[i]=eng_ready[i]&&!queue_full[i]. Combinational round-robin grant from rr
//   pointer; eng_valid=grant, eng_x/y=issue coord (driven even when no grant). On transfer: rr=winner+1 mod N,
//   coord advances x+1; at x==X_RES-1 wrap x=0,y+1. Max one issue per cycle. No eligible -> hold, no advance.
// - Collect (RUN and DRAIN): match[i]=head_valid[i]&&head_x[i]==exp_x&&head_y[i]==exp_y.
//   Output reg free when !out_valid || out_ready. If free and any match: pop lowest matching index, load
//   out_x/y/colour/sof/eol next edge, out_valid=1, advance exp coord (same wrap). Latency pop->out_valid: 1.
// - out_valid held with stable data until out_ready; back-to-back pixels at 1/cycle with out_ready=1.
// - >1 match: lowest index wins, err_multi set, stays set until reset.
// - Issue and collect are independent; both may fire in the same cycle. start during RUN/DRAIN ignored.
// - Coordinates compared unsigned, full DATA_WIDTH; counters are DATA_WIDTH wide, no overflow beyond frame.
// STRUCTURE
// - pixel_pkg: DATA_WIDTH/RBG_SIZE defaults, sched_state_t enum {IDLE,RUN,DRAIN,DONE}, raster-advance function.
// - Sub-module rr_arbiter #(N) (req, ptr -> one-hot grant); rest (FSM, coord counters, collect mux) inline.
// TESTING
// - X_RES=4,Y_RES=2,N=4, all ready, start -> eng_valid 0001,0010,0100,1000,0001.. coords (0,0)..(3,1); DRAIN.
// - queue_full=0010, eng_ready=1111 -> engine 1 never granted; order 0,2,3,0,2.. .
// - Heads present out of order ((1,0) on q2, (0,0) on q0) -> pop q0 then q2; out (0,0) sof=1, then (1,0).
// - out_ready=0 for 5 cycles with valid pixel -> out data stable, no pop; release -> resumes 1/cycle.
// - Last pixel (3,1) transferred -> done=1 for 1 cycle, busy=0, FSM IDLE; start mid-RUN ignored.
// - Two heads both (0,0) -> q0 popped, err_multi=1 sticky; reset mid-RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel scheduler: frame FSM states and the
// raster-order coordinate step.
package pixel_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RBG_SIZE   = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // True when a raster step from column x must wrap to the next line.
    function automatic logic raster_wraps(input longint unsigned x, input longint unsigned x_res);
        return x >= (x_res - 64'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr_i,
// wrapping to the lowest request when nothing at or above ptr_i is asking.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [N-1:0] thermo;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick;

    always_comb begin
        thermo  = ~((N'(1) << ptr_i) - N'(1));
        req_hi  = req_i & thermo;
        pick    = (req_hi != '0) ? req_hi : req_i;
        // Isolate the lowest set bit of the chosen request set.
        grant_o = pick & (~pick + N'(1));
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Frame sequencer: issues raster coordinates round-robin to the pixel engines and
// re-orders their queued results into a single in-order pixel stream.
module pixel_scheduler
    import pixel_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int DATA_WIDTH  = pixel_pkg::DATA_WIDTH,
    parameter int RBG_SIZE    = pixel_pkg::RBG_SIZE,
    parameter int X_RES       = 640,
    parameter int Y_RES       = 480
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start_i,
    input  logic [NUM_ENGINES-1:0]            eng_ready_i,
    input  logic [NUM_ENGINES-1:0]            queue_full_i,
    output logic [NUM_ENGINES-1:0]            eng_valid_o,
    output logic [DATA_WIDTH-1:0]             eng_x_o,
    output logic [DATA_WIDTH-1:0]             eng_y_o,
    input  logic [NUM_ENGINES-1:0]            head_valid_i,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_x_i,
    input  logic [NUM_ENGINES*DATA_WIDTH-1:0] head_y_i,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0]   head_colour_i,
    output logic [NUM_ENGINES-1:0]            pop_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [DATA_WIDTH-1:0]             out_x_o,
    output logic [DATA_WIDTH-1:0]             out_y_o,
    output logic [RBG_SIZE-1:0]               out_colour_o,
    output logic                              out_sof_o,
    output logic                              out_eol_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_multi_o
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(X_RES - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(Y_RES - 1);
    localparam logic [PW-1:0]         W_LAST = PW'(NUM_ENGINES - 1);

    sched_state_t state_q;
    logic [PW-1:0]         rr_q, rr_d;
    logic [DATA_WIDTH-1:0] iss_x_q, iss_x_d, iss_y_q, iss_y_d;
    logic [DATA_WIDTH-1:0] exp_x_q, exp_x_d, exp_y_q, exp_y_d;
    logic                  exp_done_q, exp_done_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic [RBG_SIZE-1:0]   out_colour_q, out_colour_d;
    logic                  out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic                  out_last_q, out_last_d;
    logic                  err_multi_q, err_multi_d;

    logic [NUM_ENGINES-1:0] eligible, grant, match, pop_sel;
    logic [PW-1:0]          win;
    logic [RBG_SIZE-1:0]    sel_colour;
    logic issue_fire, collect_fire, out_xfer, last_xfer;
    logic iss_last, iss_wrap, exp_wrap, exp_eol, exp_last;

    assign eligible = eng_ready_i & ~queue_full_i;

    rr_arbiter #(.N(NUM_ENGINES), .PW(PW)) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_q),
        .grant_o (grant)
    );

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_match
        assign match[g] = head_valid_i[g]
                       && (head_x_i[g*DATA_WIDTH +: DATA_WIDTH] == exp_x_q)
                       && (head_y_i[g*DATA_WIDTH +: DATA_WIDTH] == exp_y_q);
    end

    always_comb begin
        issue_fire   = (state_q == RUN) && !reset && (grant != '0);
        eng_valid_o  = issue_fire ? grant : '0;
        win          = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (grant[i]) win = PW'(i);
        end
        iss_last     = (iss_x_q == X_LAST) && (iss_y_q == Y_LAST);
        iss_wrap     = raster_wraps(64'(iss_x_q), 64'(X_RES));

        // Lowest matching queue wins; any other match is a duplicate head.
        pop_sel      = match & (~match + NUM_ENGINES'(1));
        out_xfer     = out_valid_q && out_ready_i;
        collect_fire = ((state_q == RUN) || (state_q == DRAIN)) && !exp_done_q && !reset
                    && (!out_valid_q || out_ready_i) && (match != '0);
        pop_o        = collect_fire ? pop_sel : '0;
        sel_colour   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (pop_sel[i]) sel_colour = head_colour_i[i*RBG_SIZE +: RBG_SIZE];
        end
        exp_wrap     = raster_wraps(64'(exp_x_q), 64'(X_RES));
        exp_eol      = (exp_x_q == X_LAST);
        exp_last     = exp_eol && (exp_y_q == Y_LAST);
        last_xfer    = out_xfer && out_last_q && (state_q == DRAIN);
        done_o       = last_xfer && !reset;
    end

    always_comb begin
        rr_d         = rr_q;
        iss_x_d      = iss_x_q;
        iss_y_d      = iss_y_q;
        exp_x_d      = exp_x_q;
        exp_y_d      = exp_y_q;
        exp_done_d   = exp_done_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_last_d   = out_last_q;
        err_multi_d  = err_multi_q;

        if ((state_q == IDLE) && start_i) begin
            iss_x_d    = '0;
            iss_y_d    = '0;
            exp_x_d    = '0;
            exp_y_d    = '0;
            exp_done_d = 1'b0;
        end

        if (issue_fire) begin
            rr_d    = (win == W_LAST) ? '0 : win + PW'(1);
            iss_x_d = iss_wrap ? '0 : iss_x_q + DATA_WIDTH'(1);
            iss_y_d = iss_wrap ? iss_y_q + DATA_WIDTH'(1) : iss_y_q;
        end

        if (collect_fire) begin
            out_valid_d  = 1'b1;
            out_x_d      = exp_x_q;
            out_y_d      = exp_y_q;
            out_colour_d = sel_colour;
            out_sof_d    = (exp_x_q == '0) && (exp_y_q == '0);
            out_eol_d    = exp_eol;
            out_last_d   = exp_last;
            exp_x_d      = exp_wrap ? '0 : exp_x_q + DATA_WIDTH'(1);
            exp_y_d      = exp_wrap ? exp_y_q + DATA_WIDTH'(1) : exp_y_q;
            exp_done_d   = exp_last;
            if ((match & ~pop_sel) != '0) err_multi_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            iss_x_q      <= '0;
            iss_y_q      <= '0;
            exp_x_q      <= '0;
            exp_y_q      <= '0;
            exp_done_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            err_multi_q  <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            iss_x_q      <= iss_x_d;
            iss_y_q      <= iss_y_d;
            exp_x_q      <= exp_x_d;
            exp_y_q      <= exp_y_d;
            exp_done_q   <= exp_done_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            err_multi_q  <= err_multi_d;
            case (state_q)
                IDLE:    if (start_i) state_q <= RUN;
                RUN:     if (issue_fire && iss_last) state_q <= DRAIN;
                DRAIN:   if (last_xfer) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eng_x_o      = iss_x_q;
    assign eng_y_o      = iss_y_q;
    assign out_valid_o  = out_valid_q;
    assign out_x_o      = out_x_q;
    assign out_y_o      = out_y_q;
    assign out_colour_o = out_colour_q;
    assign out_sof_o    = out_sof_q;
    assign out_eol_o    = out_eol_q;
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign err_multi_o  = err_multi_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x2 frame with four engines.
module tb_pixel_scheduler;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int RBG = 24;
    localparam int XR  = 4;
    localparam int YR  = 2;

    logic clk = 1'b0;
    logic reset, start, out_ready;
    logic [N-1:0] eng_ready, queue_full, eng_valid, head_valid, pop;
    logic [DW-1:0] eng_x, eng_y, out_x, out_y;
    logic [N*DW-1:0] head_x, head_y;
    logic [N*RBG-1:0] head_colour;
    logic [RBG-1:0] out_colour;
    logic out_valid, out_sof, out_eol, busy, done, err_multi;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pixel_scheduler #(
        .NUM_ENGINES(N), .DATA_WIDTH(DW), .RBG_SIZE(RBG), .X_RES(XR), .Y_RES(YR)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start),
        .eng_ready_i(eng_ready), .queue_full_i(queue_full),
        .eng_valid_o(eng_valid), .eng_x_o(eng_x), .eng_y_o(eng_y),
        .head_valid_i(head_valid), .head_x_i(head_x), .head_y_i(head_y),
        .head_colour_i(head_colour), .pop_o(pop),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_x_o(out_x), .out_y_o(out_y), .out_colour_o(out_colour),
        .out_sof_o(out_sof), .out_eol_o(out_eol),
        .busy_o(busy), .done_o(done), .err_multi_o(err_multi)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RBG-1:0] col(input int x, input int y);
        return RBG'(32'hC00000 + y * 16 + x);
    endfunction

    task automatic put(input int q, input int x, input int y);
        head_valid[q]             = 1'b1;
        head_x[q*DW +: DW]        = DW'(x);
        head_y[q*DW +: DW]        = DW'(y);
        head_colour[q*RBG +: RBG] = col(x, y);
    endtask

    // Next cycle: heads cleared, optional new head on queue q (q<0 = none).
    task automatic cyc_head(input int q, input int x, input int y);
        @(negedge clk);
        head_valid = '0;
        if (q >= 0) put(q, x, y);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        eng_ready = '1; queue_full = '0;
        head_valid = '0; head_x = '0; head_y = '0; head_colour = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err_multi, 0);
        chk("rst_eng_xy", {eng_x, eng_y}, 0);

        // Frame 1: all engines ready; start mid-RUN must be ignored.
        @(negedge clk); reset = 1'b0; start = 1'b1; #1;
        chk("idle_eng_valid", eng_valid, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); start = (k == 3); #1;
            chk("f1_eng_valid", eng_valid, 4'b0001 << (k % 4));
            chk("f1_eng_x", eng_x, k % 4);
            chk("f1_eng_y", eng_y, k / 4);
            chk("f1_busy", busy, 1);
        end
        @(negedge clk); start = 1'b0; #1;
        chk("drain_eng_valid", eng_valid, 0);
        chk("drain_busy", busy, 1);

        // Out-of-order heads: (1,0) on q2, (0,0) on q0.
        put(2, 1, 0); put(0, 0, 0); #1;
        chk("ooo_pop0", pop, 4'b0001);
        @(negedge clk); head_valid[0] = 1'b0; #1;
        chk("ooo_pop2", pop, 4'b0100);
        chk("ooo_out0", {out_valid, out_sof, out_eol}, 3'b110);
        chk("ooo_out0_xy", {out_x, out_y}, 0);
        chk("ooo_out0_col", out_colour, col(0, 0));
        cyc_head(-1, 0, 0);
        chk("ooo_out1", {out_valid, out_sof, out_eol}, 3'b100);
        chk("ooo_out1_x", out_x, 1);
        chk("ooo_out1_col", out_colour, col(1, 0));
        chk("ooo_nopop", pop, 0);
        cyc_head(1, 2, 0);
        chk("empty_out_valid", out_valid, 0);
        chk("bp_pop1", pop, 4'b0010);

        // Backpressure: pixel (2,0) held for 5 cycles while (3,0) waits on q3.
        @(negedge clk); out_ready = 1'b0; head_valid = '0; put(3, 3, 0); #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk("bp_pop", pop, 0);
            chk("bp_hold", {out_valid, out_x, out_y}, {1'b1, 32'd2, 32'd0});
            chk("bp_col", out_colour, col(2, 0));
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chk("bp_release_pop", pop, 4'b1000);
        cyc_head(0, 0, 1);
        chk("b2b_x3", {out_x, out_eol}, {32'd3, 1'b1});
        chk("b2b_pop0", pop, 4'b0001);
        for (int k = 1; k < 4; k++) begin
            cyc_head(k, k, 1);
            chk("b2b_xy", {out_valid, out_x, out_y}, {1'b1, 32'(k - 1), 32'd1});
            chk("b2b_pop", pop, 4'b0001 << k);
        end
        cyc_head(-1, 0, 0);
        chk("last_xy", {out_x, out_y, out_eol}, {32'd3, 32'd1, 1'b1});
        chk("last_done", done, 1);
        chk("last_busy", busy, 1);
        @(negedge clk); #1;
        chk("post_done", {done, busy, out_valid}, 0);
        @(negedge clk); #1;
        chk("idle_again", {busy, eng_valid}, 0);

        // Frame 2: engine 1's queue full -> order 0,2,3,0,2.
        @(negedge clk); reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0; queue_full = 4'b0010; start = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 0) begin put(1, 0, 0); put(3, 0, 0); end
            else head_valid = '0;
            #1;
            chk("skip_eng_valid", eng_valid, (k % 3 == 0) ? 4'b0001 : ((k % 3 == 1) ? 4'b0100 : 4'b1000));
            chk("skip_eng_x", eng_x, k % 4);
            if (k == 0) chk("dup_pop", pop, 4'b0010);
            if (k >= 1) chk("dup_err", err_multi, 1);
        end

        // Reset mid-RUN with a matching head: no pop/issue in the reset cycle.
        @(negedge clk); reset = 1'b1; put(0, 1, 0); #1;
        chk("rst_cycle_pop", pop, 0);
        chk("rst_cycle_eng_valid", eng_valid, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_outs", {busy, done, err_multi, out_valid, pop, eng_valid}, 0);
        chk("rst_coords", {eng_x, eng_y, out_x, out_y}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
